// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle RV32I control FSM driving ALU/mux selects, fetch and data-memory handshakes
// Ports: clk/rst_n (async active-low); Instr/Instr_Valid/Instr_Req fetch handshake;
// Mem_Req/Mem_We/Mem_Ready data-memory handshake; Zero/B_Flag ALU flags in;
// ALU_Select, SrcA_Sel, SrcB_Sel, Imm_Sel, Reg_Write, WB_Sel, PC_Write, PC_Sel datapath controls;
// Illegal sticky trap flag; Retired count of PC updates.
module alu_sequencer #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      Instr,
    input  logic             Instr_Valid,
    output logic             Instr_Req,
    input  logic             Mem_Ready,
    output logic             Mem_Req,
    output logic             Mem_We,
    input  logic             Zero,
    input  logic             B_Flag,
    output logic [3:0]       ALU_Select,
    output logic             SrcA_Sel,
    output logic [1:0]       SrcB_Sel,
    output logic [2:0]       Imm_Sel,
    output logic             Reg_Write,
    output logic [1:0]       WB_Sel,
    output logic             PC_Write,
    output logic             PC_Sel,
    output logic             Illegal,
    output logic [Width-1:0] Retired
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP} state_t;
    state_t state, state_nxt;
    logic [31:0] ir;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_jump, legal, taken;
    logic [3:0] alu_op;
    logic src_a;
    logic [1:0] src_b;
    logic [2:0] imm_sel;
    logic unused_ir;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign unused_ir = ^ir[24:15];
    assign is_r      = opcode == 7'b0110011;
    assign is_i      = opcode == 7'b0010011;
    assign is_ld     = opcode == 7'b0000011;
    assign is_st     = opcode == 7'b0100011;
    assign is_br     = opcode == 7'b1100011;
    assign is_jal    = opcode == 7'b1101111;
    assign is_jalr   = opcode == 7'b1100111;
    assign is_lui    = opcode == 7'b0110111;
    assign is_auipc  = opcode == 7'b0010111;
    assign is_jump   = is_jal | is_jalr;
    assign legal     = is_r  ? (funct7 == 7'b0000000 ||
                               (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) :
                       is_br ? funct3[2:1] != 2'b01 :
                       (is_i | is_ld | is_st | is_jump | is_lui | is_auipc);
    // funct3[2] selects the B_Flag compares; funct3[0] inverts the equality test for BNE
    assign taken     = funct3[2] ? B_Flag : (Zero ^ funct3[0]);

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? 4'b0001 : 4'b0000;
            3'b001:  arith_op = 4'b0011;
            3'b010:  arith_op = 4'b1001;
            3'b011:  arith_op = 4'b1010;
            3'b100:  arith_op = 4'b1000;
            3'b101:  arith_op = alt ? 4'b0101 : 4'b0100;
            3'b110:  arith_op = 4'b0111;
            default: arith_op = 4'b0110;
        endcase
    endfunction

    function automatic logic [3:0] branch_op(input logic [2:0] f3);
        case (f3)
            3'b100:  branch_op = 4'b1011;
            3'b101:  branch_op = 4'b1100;
            3'b110:  branch_op = 4'b1101;
            3'b111:  branch_op = 4'b1110;
            default: branch_op = 4'b0001;
        endcase
    endfunction

    // ALU/mux selects per instruction class; loads, stores and jumps default to add
    always_comb begin
        alu_op  = 4'b0000;
        src_a   = 1'b0;
        src_b   = 2'd0;
        imm_sel = 3'd0;
        if (is_r) alu_op = arith_op(funct3, funct7[5]);
        if (is_i) begin
            alu_op = arith_op(funct3, funct3 == 3'b101 && funct7[5]);
            src_b  = 2'd1;
        end
        if (is_ld | is_jalr) src_b = 2'd1;
        if (is_st) begin
            src_b   = 2'd1;
            imm_sel = 3'd1;
        end
        if (is_br) begin
            alu_op  = branch_op(funct3);
            src_a   = 1'b1;
            src_b   = 2'd1;
            imm_sel = 3'd2;
        end
        if (is_lui) begin
            alu_op  = 4'b0010;
            src_b   = 2'd1;
            imm_sel = 3'd3;
        end
        if (is_auipc | is_jal) begin
            src_a   = 1'b1;
            src_b   = 2'd1;
            imm_sel = is_jal ? 3'd4 : 3'd3;
        end
    end

    // ALU selects stay driven through MEMORY and WRITEBACK since the result feeds address and writeback unregistered
    always_comb begin
        state_nxt  = state;
        Instr_Req  = 1'b0;
        Mem_Req    = 1'b0;
        Mem_We     = 1'b0;
        ALU_Select = 4'b0000;
        SrcA_Sel   = 1'b0;
        SrcB_Sel   = 2'd0;
        Imm_Sel    = 3'd0;
        Reg_Write  = 1'b0;
        WB_Sel     = 2'd0;
        PC_Write   = 1'b0;
        PC_Sel     = 1'b0;
        if (state == EXECUTE || state == MEMORY || state == WRITEBACK) begin
            ALU_Select = alu_op;
            SrcA_Sel   = src_a;
            SrcB_Sel   = src_b;
            Imm_Sel    = imm_sel;
        end
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                Instr_Req = 1'b1;
                state_nxt = Instr_Valid ? DECODE : FETCH;
            end
            DECODE: state_nxt = legal ? EXECUTE : TRAP;
            EXECUTE: begin
                PC_Write  = is_br;
                PC_Sel    = is_br & taken;
                state_nxt = is_br ? FETCH : (is_ld | is_st) ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                Mem_Req   = 1'b1;
                Mem_We    = is_st;
                PC_Write  = is_st & Mem_Ready;
                state_nxt = !Mem_Ready ? MEMORY : is_st ? FETCH : WRITEBACK;
            end
            WRITEBACK: begin
                Reg_Write = ir[11:7] != 5'd0;
                WB_Sel    = is_ld ? 2'd1 : is_jump ? 2'd2 : 2'd0;
                PC_Write  = 1'b1;
                PC_Sel    = is_jump;
                state_nxt = FETCH;
            end
            TRAP: state_nxt = TRAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ir      <= '0;
            Illegal <= 1'b0;
            Retired <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && Instr_Valid) ir <= Instr;
            if (state == DECODE && !legal) Illegal <= 1'b1;
            if (PC_Write) Retired <= Retired + Width'(1);
        end
    end
endmodule
